// File: rtl/spi_reg_arbiter.sv
// Register bank shared by the SPI register slave and the local design.
// SPI writes are single-cycle and always win; the local side uses a
// req/gnt handshake and is deferred (PEND) while SPI traffic collides.
// Also produces the sticky status byte loaded by the SPI slave.
module spi_reg_arbiter #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8,
  parameter logic [(2**ADDR_W)-1:0] RO_MASK = 8'b1000_0000
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ena,
  input  logic [ADDR_W-1:0]             spi_addr,
  input  logic [REG_W-1:0]              spi_wdata,
  input  logic                          spi_wdata_dv,
  output logic [REG_W-1:0]              spi_rdata,
  input  logic                          loc_req,
  input  logic [ADDR_W-1:0]             loc_addr,
  input  logic [REG_W-1:0]              loc_wdata,
  output logic                          loc_gnt,
  output logic [REG_W-1:0]              loc_rdata,
  input  logic                          stat_clr,
  output logic [(2**ADDR_W)*REG_W-1:0]  regs_o,
  output logic [7:0]                    status
);

  localparam int NREG = 2**ADDR_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [REG_W-1:0] bank_q [NREG];
  logic [1:0]       state_q, state_d;
  logic             gnt_q;
  logic             coll_q, coll_d;
  logic             ro_err_q, ro_err_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             spi_ro, spi_we, loc_we, coll_evt;

  // Arbitration: SPI strobe decides; local write only in a cycle with no strobe
  always_comb begin
    spi_ro   = RO_MASK[spi_addr];
    spi_we   = spi_wdata_dv && !spi_ro;
    state_d  = state_q;
    loc_we   = 1'b0;
    coll_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (loc_req) begin
          if (spi_wdata_dv) begin
            coll_evt = 1'b1;
            state_d  = PEND;
          end else begin
            loc_we  = 1'b1;
            state_d = ACK;
          end
        end
      end
      PEND: begin
        // A dropped request abandons the pending write entirely
        if (!loc_req) begin
          state_d = IDLE;
        end else if (spi_wdata_dv) begin
          coll_evt = 1'b1;
        end else begin
          loc_we  = 1'b1;
          state_d = ACK;
        end
      end
      // ACK never accepts, so a request still held here is not written twice
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags and write counter; a set event in the clear cycle wins
  always_comb begin
    coll_d   = coll_evt | (coll_q & ~stat_clr);
    ro_err_d = (spi_wdata_dv & spi_ro) | (ro_err_q & ~stat_clr);
    cnt_d    = stat_clr ? {3'b000, spi_we} : cnt_q + {3'b000, spi_we};
  end

  // Control state: FSM, registered grant, status flags and counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      coll_q   <= 1'b0;
      ro_err_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else if (ena) begin
      state_q  <= state_d;
      gnt_q    <= (state_d == ACK);
      coll_q   <= coll_d;
      ro_err_q <= ro_err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Register bank; SPI and local writes never coincide in one cycle
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < NREG; i++) begin
        if (spi_we && (spi_addr == ADDR_W'(i))) begin
          bank_q[i] <= spi_wdata;
        end else if (loc_we && (loc_addr == ADDR_W'(i))) begin
          bank_q[i] <= loc_wdata;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_flat
      assign regs_o[gi*REG_W +: REG_W] = bank_q[gi];
    end
  endgenerate

  assign spi_rdata = bank_q[spi_addr];
  assign loc_rdata = bank_q[loc_addr];
  assign loc_gnt   = gnt_q;
  assign status    = {coll_q, ro_err_q, (state_q == PEND), 1'b0, cnt_q};

endmodule
